// File: rtl/dmg_seq_pkg.sv
// ============================================================================
// Module : dmg_seq_pkg
// Brief  : Shared widths, default opcodes and Decoder1 vector index map for
//          the opcode sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmg_seq_pkg;

  localparam int IR_W = 8;
  localparam int ST_W = 3;
  localparam int A_W  = 26;

  localparam logic [IR_W-1:0] CB_OPCODE_DEF = 8'hCB;
  localparam logic [IR_W-1:0] NOP_OPCODE    = 8'h00;

  // True-rail positions in a[]; each complement rail sits at index-1.
  localparam int A_INTR = 1;
  localparam int A_CB   = 3;
  localparam int A_IR7  = 5;
  localparam int A_IR6  = 7;
  localparam int A_IR5  = 9;
  localparam int A_IR4  = 11;
  localparam int A_IR3  = 13;
  localparam int A_IR2  = 15;
  localparam int A_IR1  = 17;
  localparam int A_IR0  = 19;
  localparam int A_ST2  = 21;
  localparam int A_ST1  = 23;
  localparam int A_ST0  = 25;

  // Register image presented to the encoder.
  typedef struct packed {
    logic            intr_disp;
    logic            cb_mode;
    logic [IR_W-1:0] ir;
    logic [ST_W-1:0] state;
  } seq_regs_t;

  // True-rail position of ir[bit]: ir is laid out MSB first from A_IR7.
  function automatic int ir_true_idx(input int bit_pos);
    return A_IR7 + 2 * (IR_W - 1 - bit_pos);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_a_encode.sv
// ============================================================================
// Module : seq_a_encode
// Brief  : Combinational true/complement encoder producing the Decoder1
//          input vector from the sequencer registers.
// Ports  : regs (in, seq_regs_t)  intr_disp, cb_mode, ir, state
//          a    (out, 26)         Decoder1 vector
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_a_encode
  import dmg_seq_pkg::*;
(
  input  seq_regs_t        regs,
  output logic [A_W-1:0]   a
);

  assign a[A_INTR]   =  regs.intr_disp;
  assign a[A_INTR-1] = ~regs.intr_disp;
  assign a[A_CB]     =  regs.cb_mode;
  assign a[A_CB-1]   = ~regs.cb_mode;

  generate
    for (genvar b = 0; b < IR_W; b++) begin : g_ir
      assign a[ir_true_idx(b)]   =  regs.ir[b];
      assign a[ir_true_idx(b)-1] = ~regs.ir[b];
    end
  endgenerate

  assign a[A_ST2]   =  regs.state[2];
  assign a[A_ST2-1] = ~regs.state[2];
  assign a[A_ST1]   =  regs.state[1];
  assign a[A_ST1-1] = ~regs.state[1];
  assign a[A_ST0]   =  regs.state[0];
  assign a[A_ST0-1] = ~regs.state[0];

endmodule

`default_nettype wire

// File: rtl/opcode_sequencer.sv
// ============================================================================
// Module : opcode_sequencer
// Brief  : Opcode latch, CB-prefix / interrupt-dispatch mode tracking and
//          M-cycle state counter feeding Decoder1.
// Config : SEQ_OVF_CHECK_EN - when defined, the state counter saturates at 7
//          on overflow and sets the sticky seq_ovf flag; otherwise it wraps
//          and seq_ovf is tied low.
// Ports  : CLK, RESET (async, active-high), m_tick, halt_hold, instr_end,
//          int_take, dbus[7:0]  -> ir[7:0], state[2:0], cb_mode, intr_disp,
//          seq_ovf, a[25:0]
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module opcode_sequencer
  import dmg_seq_pkg::*;
#(
  parameter logic [IR_W-1:0] RESET_IR  = NOP_OPCODE,
  parameter logic [IR_W-1:0] CB_OPCODE = CB_OPCODE_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             m_tick,
  input  logic             halt_hold,
  input  logic             instr_end,
  input  logic             int_take,
  input  logic [IR_W-1:0]  dbus,
  output logic [IR_W-1:0]  ir,
  output logic [ST_W-1:0]  state,
  output logic             cb_mode,
  output logic             intr_disp,
  output logic             seq_ovf,
  output logic [A_W-1:0]   a
);

  localparam logic [ST_W-1:0] ST_MAX = {ST_W{1'b1}};

  logic advance;
  logic prefix_pending;

  assign advance = m_tick & ~halt_hold;

  // A bare CB prefix is in ir: the next fetch is a CB-page opcode, and an
  // interrupt must not be taken between the prefix and that opcode.
  assign prefix_pending = (ir == CB_OPCODE) & ~cb_mode & ~intr_disp;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ir        <= RESET_IR;
      cb_mode   <= 1'b0;
      intr_disp <= 1'b0;
    end else if (advance && instr_end) begin
      if (int_take && !prefix_pending) begin
        ir        <= NOP_OPCODE;
        cb_mode   <= 1'b0;
        intr_disp <= 1'b1;
      end else begin
        ir        <= dbus;
        cb_mode   <= prefix_pending;
        intr_disp <= 1'b0;
      end
    end
  end

`ifdef SEQ_OVF_CHECK_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= '0;
      seq_ovf <= 1'b0;
    end else if (advance) begin
      if (instr_end) begin
        state <= '0;
      end else if (state == ST_MAX) begin
        seq_ovf <= 1'b1;
      end else begin
        state <= state + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= '0;
    end else if (advance) begin
      if (instr_end) begin
        state <= '0;
      end else begin
        // Wraps 7 -> 0 naturally.
        state <= state + 1'b1;
      end
    end
  end

  assign seq_ovf = 1'b0;
`endif

  seq_regs_t regs;

  assign regs.intr_disp = intr_disp;
  assign regs.cb_mode   = cb_mode;
  assign regs.ir        = ir;
  assign regs.state     = state;

  seq_a_encode u_a_encode (
    .regs (regs),
    .a    (a)
  );

endmodule

`default_nettype wire
